// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding and latency limits.
package data_mem_responder_pkg;

  localparam int LATENCY_MAX_LP = 15;
  localparam int CNT_W_LP       = $clog2(LATENCY_MAX_LP + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_responder_array.sv
// Word storage for the data memory responder: synchronous write, combinational read, never reset.
module data_mem_array #(
  parameter int DATA_WIDTH_P = 32,
  parameter int DEPTH_P      = 256,
  parameter int IDX_W_P      = 8
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [IDX_W_P-1:0]      addr_i,
  input  logic [DATA_WIDTH_P-1:0] wdata_i,
  output logic [DATA_WIDTH_P-1:0] rdata_o
);

  logic [DATA_WIDTH_P-1:0] mem_q [DEPTH_P];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder with fixed per-access latency and range checking.
// Optional build macro DATA_MEM_ALIGN_CHECK_EN flags misaligned byte addresses as errors.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH_P      = 32,
  parameter int DATA_ADDR_WIDTH_P = 32,
  parameter int DEPTH_P           = 256,
  parameter int LATENCY_P         = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_mem_req,
  input  logic                         i_mem_wr_en,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_mem_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_mem_wr_data,
  output logic                         o_mem_ready,
  output logic [DATA_WIDTH_P-1:0]      o_mem_rd_data,
  output logic                         o_mem_rd_valid,
  output logic                         o_mem_wr_ack,
  output logic                         o_mem_err
);

  localparam int IDX_W_LP = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam logic [DATA_ADDR_WIDTH_P-1:0] DEPTH_WORDS_LP = DATA_ADDR_WIDTH_P'(DEPTH_P);
  localparam logic [CNT_W_LP-1:0] LAT_INIT_LP = CNT_W_LP'(LATENCY_P);
  localparam logic [CNT_W_LP-1:0] CNT_ONE_LP  = CNT_W_LP'(1);
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK_LP = 1'b1;
`else
  localparam logic ALIGN_CHECK_LP = 1'b0;
`endif

  state_e                         state_q, state_d;
  logic [CNT_W_LP-1:0]            cnt_q, cnt_d;
  logic                           wr_en_q, wr_en_d;
  logic [DATA_ADDR_WIDTH_P-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH_P-1:0]        wr_data_q, wr_data_d;
  logic [DATA_WIDTH_P-1:0]        rd_data_q, rd_data_d;
  logic                           rd_valid_q, rd_valid_d;
  logic                           wr_ack_q, wr_ack_d;
  logic                           err_q, err_d;
  logic                           access_s, oob_s, misalign_s, err_s, mem_we_s;
  logic [DATA_WIDTH_P-1:0]        mem_rd_s;

  assign oob_s      = ({2'b00, addr_q[DATA_ADDR_WIDTH_P-1:2]} >= DEPTH_WORDS_LP);
  assign misalign_s = |addr_q[1:0];
  assign err_s      = oob_s | (ALIGN_CHECK_LP & misalign_s);
  assign mem_we_s   = access_s & wr_en_q & ~err_s;

  data_mem_array #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .DEPTH_P      (DEPTH_P),
    .IDX_W_P      (IDX_W_LP)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .addr_i  (addr_q[IDX_W_LP+1:2]),
    .wdata_i (wr_data_q),
    .rdata_o (mem_rd_s)
  );

  // Next-state, request latch and completion-pulse logic; the access itself happens on the WAIT->RESP edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ack_d   = 1'b0;
    err_d      = 1'b0;
    access_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_mem_req) begin
          state_d   = ST_WAIT;
          cnt_d     = LAT_INIT_LP;
          wr_en_d   = i_mem_wr_en;
          addr_d    = i_mem_addr;
          wr_data_d = i_mem_wr_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE_LP;
        end else begin
          access_s = 1'b1;
          state_d  = ST_RESP;
          err_d    = err_s;
          if (wr_en_q) begin
            wr_ack_d = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = err_s ? '0 : mem_rd_s;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, latched request and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      err_q      <= err_d;
    end
  end

  assign o_mem_ready    = (state_q == ST_IDLE);
  assign o_mem_rd_data  = rd_data_q;
  assign o_mem_rd_valid = rd_valid_q;
  assign o_mem_wr_ack   = wr_ack_q;
  assign o_mem_err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table plus scoreboard, with hand-written
// sequences for back-to-back requests, mid-access reset and a zero-latency instance.
module tb_data_mem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          due;
    logic        is_rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        ready, rd_valid, wr_ack, err;
  logic [31:0] rd_data;

  logic        req0 = 1'b0, wr_en0 = 1'b0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic        ready0, rd_valid0, wr_ack0, err0;
  logic [31:0] rd_data0;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = 32'h0;
  exp_t        sb[$];
  vec_t        vecs[15];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(
    .DATA_WIDTH_P(32), .DATA_ADDR_WIDTH_P(32), .DEPTH_P(256), .LATENCY_P(LAT)
  ) u_dut (
    .clk(clk), .reset(reset), .i_mem_req(req), .i_mem_wr_en(wr_en),
    .i_mem_addr(addr), .i_mem_wr_data(wdata), .o_mem_ready(ready),
    .o_mem_rd_data(rd_data), .o_mem_rd_valid(rd_valid), .o_mem_wr_ack(wr_ack),
    .o_mem_err(err)
  );

  data_mem_responder #(
    .DATA_WIDTH_P(32), .DATA_ADDR_WIDTH_P(32), .DEPTH_P(256), .LATENCY_P(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .i_mem_req(req0), .i_mem_wr_en(wr_en0),
    .i_mem_addr(addr0), .i_mem_wr_data(wdata0), .o_mem_ready(ready0),
    .o_mem_rd_data(rd_data0), .o_mem_rd_valid(rd_valid0), .o_mem_wr_ack(wr_ack0),
    .o_mem_err(err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the main instance: pulses must match queued expectations exactly.
  always @(negedge clk) begin
    if (reset) begin
      last_rd = 32'h0;
    end else if (rd_valid || wr_ack || err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_pulse: got rd_valid=%b wr_ack=%b err=%b expected no pulse (cycle %0d)",
                 rd_valid, wr_ack, err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.due));
        check("rd_valid", 32'(rd_valid), 32'(e.is_rd));
        check("wr_ack", 32'(wr_ack), 32'(!e.is_rd));
        check("err", 32'(err), 32'(e.err));
        if (e.is_rd) last_rd = e.data;
        check("rd_data", rd_data, last_rd);
      end
    end else begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse: got none expected completion at cycle %0d (now %0d)", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      check("rd_data_hold", rd_data, last_rd);
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic eerr, input logic [31:0] erd);
    int   n;
    exp_t e;
    n = cyc;
    check("ready_idle", 32'(ready), 32'h1);
    req = 1'b1; wr_en = w; addr = a; wdata = d;
    next_cycle();
    req = 1'b0;
    e.due = n + LAT + 2; e.is_rd = !w; e.err = eerr; e.data = erd;
    sb.push_back(e);
    repeat (LAT + 2) next_cycle();
  endtask

  task automatic lat0_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] erd);
    check("lat0_ready", 32'(ready0), 32'h1);
    req0 = 1'b1; wr_en0 = w; addr0 = a; wdata0 = d;
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    check("lat0_no_early", 32'(rd_valid0 | wr_ack0), 32'h0);
    next_cycle();
    @(negedge clk);
    check("lat0_rd_valid", 32'(rd_valid0), 32'(!w));
    check("lat0_wr_ack", 32'(wr_ack0), 32'(w));
    check("lat0_err", 32'(err0), 32'h0);
    if (!w) check("lat0_rd_data", rd_data0, erd);
    next_cycle();
    @(negedge clk);
    check("lat0_no_late", 32'(rd_valid0 | wr_ack0), 32'h0);
    next_cycle();
  endtask

  initial begin
    logic align_chk;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    align_chk = 1'b1;
`else
    align_chk = 1'b0;
`endif
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0000_0014, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0400, 32'h1111_1111, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_C0DE, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0BAD_C0DE};
    vecs[10] = '{1'b1, 32'h0000_0020, 32'h1212_1212, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0022, 32'h0000_0077, align_chk, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0,
                 align_chk ? 32'h1212_1212 : 32'h0000_0077};
    vecs[13] = '{1'b0, 32'h0000_03FF, 32'h0,         align_chk,
                 align_chk ? 32'h0 : 32'h0BAD_C0DE};
    vecs[14] = '{1'b1, 32'h0000_0020, 32'h2468_2468, 1'b0, 32'h0};

    #1 reset = 1'b1;
    #2;
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_wr_ack", 32'(wr_ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_err, vecs[i].exp_rd);
    end

    // Request held high: one read accepted every LAT+3 cycles, others ignored.
    begin
      int s;
      exp_t e;
      s = cyc;
      req = 1'b1; wr_en = 1'b0; addr = 32'h10;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        check("busy_ready", 32'(ready), 32'((c % 5) == 0));
        if ((c % 5) == 0) begin
          e.due = s + c + 4; e.is_rd = 1'b1; e.err = 1'b0; e.data = 32'hDEAD_BEEF;
          sb.push_back(e);
        end
        next_cycle();
      end
      req = 1'b0;
      next_cycle();
    end

    // Reset during WAIT of a write: outputs return to reset values and the write is lost.
    check("pre_rst_ready", 32'(ready), 32'h1);
    req = 1'b1; wr_en = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    next_cycle();
    req = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready), 32'h1);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'h0);
    check("mid_rst_wr_ack", 32'(wr_ack), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_rd_data", rd_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    next_cycle();
    issue(1'b0, 32'h20, 32'h0, 1'b0, 32'h2468_2468);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Zero-latency instance: completion two cycles after the request cycle.
    lat0_access(1'b1, 32'h10, 32'h5555_AAAA, 32'h0);
    lat0_access(1'b0, 32'h10, 32'h0, 32'h5555_AAAA);
    lat0_access(1'b1, 32'h44, 32'h0F0F_0F0F, 32'h0);
    lat0_access(1'b0, 32'h44, 32'h0, 32'h0F0F_0F0F);

    repeat (3) next_cycle();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 32, data word width.
REQ-002 SHALL have parameter DATA_ADDR_WIDTH_P, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH_P, default 256, number of words stored.
REQ-004 SHALL have parameter LATENCY_P, default 2, wait cycles per access (0..15).
REQ-005 SHALL have a single clock and a reset that is asynchronous and active-high; ports are listed below.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 i_mem_req  input  1  initiator request valid.
REQ-009 i_mem_wr_en  input  1  1 = write, 0 = read; qualified by i_mem_req.
REQ-010 i_mem_addr  input  DATA_ADDR_WIDTH_P  byte address.
REQ-011 i_mem_wr_data  input  DATA_WIDTH_P  write data.
REQ-012 o_mem_ready  output  1  responder can accept a request this cycle.
REQ-013 o_mem_rd_data  output  DATA_WIDTH_P  read data, valid with o_mem_rd_valid.
REQ-014 o_mem_rd_valid  output  1  one-cycle read-completion pulse.
REQ-015 o_mem_wr_ack  output  1  one-cycle write-completion pulse.
REQ-016 o_mem_err  output  1  one-cycle error pulse, coincident with the completion pulse.

Function
REQ-017 SHALL accept a request on a rising edge where i_mem_req=1 and o_mem_ready=1, latching address, write enable and write data.
REQ-018 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: o_mem_ready=1; on accept, go to WAIT with counter=LATENCY_P.
  - WAIT: counter>0 decrements; counter=0 performs the access at that edge and goes to RESP.
  - RESP: completion pulse; returns to IDLE.
REQ-019 SHALL hold o_mem_ready=0 in WAIT and RESP; requests presented there are ignored, not queued.
REQ-020 For a request accepted in cycle N, SHALL assert the completion pulse in cycle N+LATENCY_P+2 only.
REQ-021 SHALL index words by i_mem_addr[log2(DEPTH_P)+1:2]; addresses at or above DEPTH_P*4 SHALL set o_mem_err, suppress writes and return read data 0.
REQ-022 SHALL commit a write to the array only at the WAIT->RESP edge.
REQ-023 SHALL hold o_mem_rd_data at its last value outside RESP, and at 0 after reset.
REQ-024 A read of a word written by the immediately preceding request SHALL return the new data.

Reset
REQ-025 On reset assertion SHALL immediately force IDLE, counter=0, o_mem_ready=1, o_mem_rd_valid=0, o_mem_wr_ack=0, o_mem_err=0, o_mem_rd_data=0.
REQ-026 Reset mid-access SHALL abort the access; a write not yet committed SHALL NOT reach the array.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro DATA_MEM_ALIGN_CHECK_EN defined, a request with i_mem_addr[1:0]!=0 SHALL complete with o_mem_err=1, write suppressed, read data 0.
REQ-029 Without DATA_MEM_ALIGN_CHECK_EN, i_mem_addr[1:0] SHALL be ignored.

Structure
REQ-030 FSM state encoding and the maximum LATENCY_P constant SHALL live in the shared core package.
REQ-031 The storage array SHALL be a sub-module named data_mem_array (sync write, combinational read); FSM and handshake stay in data_mem_responder.

Verification
REQ-032 Reset, write 0xDEADBEEF to 0x10, read 0x10 -> o_mem_wr_ack in cycle N+4; o_mem_rd_valid with 0xDEADBEEF 4 cycles after read accept.
REQ-033 i_mem_req held high continuously -> o_mem_ready low in WAIT/RESP; exactly one access per 5 cycles at LATENCY_P=2; no extra accesses.
REQ-034 Read address 0x400 with DEPTH_P=256 -> o_mem_err=1, o_mem_rd_data=0; a following write to 0x400 leaves word 0 unchanged.
REQ-035 Assert reset during WAIT of a write of 0x12345678 to 0x20 -> all outputs at reset values; a later read of 0x20 returns the prior value.
REQ-036 With DATA_MEM_ALIGN_CHECK_EN, write to 0x22 -> o_mem_err=1, no write; without the macro, same write lands in word 8.
REQ-037 LATENCY_P=0: read accepted in cycle N -> o_mem_rd_valid in cycle N+2.
